// File: rtl/lcd_scan_pkg.sv
// -----------------------------------------------------------------------------
// lcd_scan_pkg
// Shared definitions for the LCD common/segment scanner.
//   snap_state_t     : states of the display-RAM snapshot FSM
//   STEP_DIV_DEFAULT : clk cycles per common step (50 MHz / 8192)
//   cnt_width()      : number of bits needed to count 0..div-1
// -----------------------------------------------------------------------------
package lcd_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } snap_state_t;

   localparam int STEP_DIV_DEFAULT = 6103;

   // A divisor of 1 or 2 still gets a one-bit counter so the timer never
   // degenerates into a zero-width vector.
   function automatic int cnt_width(input int div);
      if (div <= 2) begin
         return 1;
      end
      return $clog2(div);
   endfunction

endpackage : lcd_scan_pkg

// File: rtl/lcd_step_timer.sv
// -----------------------------------------------------------------------------
// lcd_step_timer
// Free-running divider that emits a one-cycle enable every DIV clk cycles.
// Used for the LCD common step, and equally usable for buzzer or timebase
// clock enables.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high; counter returns to 0
//   freeze in   holds the counter; no tick is produced while high
//   tick   out  high on the cycle the counter equals DIV-1 (combinational)
// -----------------------------------------------------------------------------
module lcd_step_timer
   import lcd_scan_pkg::*;
#(
   parameter int DIV = STEP_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic freeze,
   output logic tick
);

   localparam int            CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   generate
      if (DIV < 1) begin : g_div_check
         $error("lcd_step_timer: DIV must be at least 1");
      end
   endgenerate

   // Tick is qualified by freeze so a frozen counter sitting on LAST does not
   // keep firing; the count resumes from where it stopped.
   assign tick = !freeze && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (!freeze) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule : lcd_step_timer

// File: rtl/lcd_scan_driver.sv
// -----------------------------------------------------------------------------
// lcd_scan_driver
// LCD common/segment scanner for SM5xx-style Game & Watch cores.
// A snapshot FSM copies NUM_SEG display-RAM words into a shadow buffer; the
// shadow is swapped into the active buffer only when the common index wraps
// to 0, so a displayed frame never mixes old and new RAM contents. A step
// timer advances the one-hot common and drives the segment and Bs lines.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   ram_rd     out  read strobe, one cycle per word
//   ram_addr   out  read address (RAM_BASE + word), valid while ram_rd high
//   ram_dout   in   read data, sampled RD_LAT cycles after ram_rd
//   bp_en      in   backplate enable; 0 blanks all segments
//   bs_pat     in   Bs level per common
//   freeze     in   holds the step counter and common index
//   com        out  one-hot active common
//   seg        out  segment lines for the active common
//   bs         out  Bs line for the active common
//   frame_sync out  one-cycle pulse when common 0 becomes active
//   snap_busy  out  snapshot FSM not idle (REQ, WAIT or DONE)
//
// Read port: ram_rd is a single-cycle request with ram_addr valid in the same
// cycle; there is no ready/back-pressure. The RAM must present the word on
// ram_dout exactly RD_LAT cycles later, where it is captured once.
// -----------------------------------------------------------------------------
module lcd_scan_driver
   import lcd_scan_pkg::*;
#(
   parameter int                NUM_COM  = 4,
   parameter int                NUM_SEG  = 32,
   parameter int                RAM_AW   = 7,
   parameter int                RAM_DW   = 4,
   parameter logic [RAM_AW-1:0] RAM_BASE = 7'h60,
   parameter int                RD_LAT   = 1,
   parameter int                STEP_DIV = STEP_DIV_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   output logic               ram_rd,
   output logic [RAM_AW-1:0]  ram_addr,
   input  logic [RAM_DW-1:0]  ram_dout,
   input  logic               bp_en,
   input  logic [NUM_COM-1:0] bs_pat,
   input  logic               freeze,
   output logic [NUM_COM-1:0] com,
   output logic [NUM_SEG-1:0] seg,
   output logic               bs,
   output logic               frame_sync,
   output logic               snap_busy
);

   localparam int IW = $clog2(NUM_COM);
   localparam int WW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_COM - 1);
   localparam logic [WW-1:0]      LAST_WORD = WW'(NUM_SEG - 1);
   localparam logic [LW-1:0]      LAST_WAIT = LW'(RD_LAT - 1);
   localparam logic [NUM_COM-1:0] COM_ONE   = NUM_COM'(1);

   // ---------------------------------------------------------------------------
   // Elaboration checks
   // ---------------------------------------------------------------------------
   generate
      if (RAM_DW < NUM_COM) begin : g_dw_check
         $error("lcd_scan_driver: RAM_DW must be >= NUM_COM");
      end
      if (NUM_COM < 2 || NUM_COM > 8) begin : g_com_check
         $error("lcd_scan_driver: NUM_COM must be in 2..8");
      end
      if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_check
         $error("lcd_scan_driver: RD_LAT must be in 1..3");
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Step timer
   // ---------------------------------------------------------------------------
   logic tick;

   lcd_step_timer #(
      .DIV (STEP_DIV)
   ) u_step_timer (
      .clk    (clk),
      .rst    (rst),
      .freeze (freeze),
      .tick   (tick)
   );

   // ---------------------------------------------------------------------------
   // Frame buffers and swap control
   // ---------------------------------------------------------------------------
   logic [NUM_COM-1:0] active [NUM_SEG];
   logic [NUM_COM-1:0] shadow [NUM_SEG];
   logic               pending;
   logic [IW-1:0]      idx;
   logic [IW-1:0]      nidx;
   logic               wrap;
   logic               swap;
   logic [NUM_SEG-1:0] seg_next;

   assign nidx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
   assign wrap = tick && (nidx == '0);
   // pending is only ever set by DONE while it is still 0, so a DONE landing
   // on the wrap cycle is not swapped until the following wrap.
   assign swap = wrap && pending;

   // On a swapping wrap the common-0 segments already come from the frame
   // being swapped in, so the new frame starts cleanly on common 0.
   always_comb begin
      seg_next = '0;
      for (int s = 0; s < NUM_SEG; s++) begin
         seg_next[s] = (swap ? shadow[s][nidx] : active[s][nidx]) & bp_en;
      end
   end

   // ---------------------------------------------------------------------------
   // Snapshot FSM: state register
   // ---------------------------------------------------------------------------
   snap_state_t   state;
   snap_state_t   state_next;
   logic [WW-1:0] word;
   logic [LW-1:0] wcnt;
   logic          wait_end;
   logic          capture;
   logic          snap_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign wait_end = (wcnt == LAST_WAIT);

   // ---------------------------------------------------------------------------
   // Snapshot FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!pending) begin
               state_next = REQ;
            end
         end
         REQ: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (wait_end) begin
               state_next = (word == LAST_WORD) ? DONE : REQ;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Snapshot FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      ram_rd    = 1'b0;
      snap_busy = 1'b0;
      capture   = 1'b0;
      snap_done = 1'b0;
      case (state)
         REQ: begin
            ram_rd    = 1'b1;
            snap_busy = 1'b1;
         end
         WAIT: begin
            snap_busy = 1'b1;
            capture   = wait_end;
         end
         DONE: begin
            snap_busy = 1'b1;
            snap_done = 1'b1;
         end
         default: begin
            ram_rd    = 1'b0;
         end
      endcase
   end

   // Address wraps modulo 2^RAM_AW by construction of the sum width.
   assign ram_addr = RAM_BASE + RAM_AW'(word);

   // ---------------------------------------------------------------------------
   // Snapshot datapath: word index, latency counter, shadow buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         word <= '0;
         wcnt <= '0;
         for (int s = 0; s < NUM_SEG; s++) begin
            shadow[s] <= '0;
         end
      end else begin
         if (state == WAIT) begin
            if (wait_end) begin
               wcnt <= '0;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
         end
         if (capture) begin
            shadow[word] <= ram_dout[NUM_COM-1:0];
            if (word != LAST_WORD) begin
               word <= word + 1'b1;
            end
         end
         if (snap_done) begin
            word <= '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pending flag and active buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (swap) begin
         pending <= 1'b0;
      end else if (snap_done) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SEG; s++) begin
            active[s] <= '0;
         end
      end else if (swap) begin
         for (int s = 0; s < NUM_SEG; s++) begin
            active[s] <= shadow[s];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registered scan outputs; idx resets to the last common so the first tick
   // selects common 0.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= LAST_IDX;
         com        <= '0;
         seg        <= '0;
         bs         <= 1'b0;
         frame_sync <= 1'b0;
      end else begin
         frame_sync <= wrap;
         if (tick) begin
            idx <= nidx;
            com <= COM_ONE << nidx;
            seg <= seg_next;
            bs  <= bs_pat[nidx];
         end
      end
   end

endmodule : lcd_scan_driver
